// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared types and defaults for the serial pattern scanner.
//   state_e     - controller FSM states
//   *_DEF       - default widths for word, pattern and counters
//   MAX_WORDS   - largest number of words a single scan can cover
package seq_scan_pkg;
  localparam int WORD_W_DEF = 16;
  localparam int PAT_W_DEF  = 12;
  localparam int CNT_W_DEF  = 16;
  localparam int MAX_WORDS  = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: bit-serial history and length-masked pattern compare.
//   clk, reset          - clock, async active-low reset
//   clr_i               - drop history and fill count (scan start)
//   bit_valid_i, bit_i  - one stream bit per cycle when valid
//   cfg_pattern_i/len_i - pattern; bit [len-1] is the oldest expected bit
//   cfg_overlap_i       - 0: restart fill after a match
//   match_o             - combinational: the bit being shifted completes a match
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  input  logic [PAT_W-1:0] cfg_pattern_i,
  input  logic [3:0]       cfg_len_i,
  input  logic             cfg_overlap_i,
  output logic             match_o
);
  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  w_hist_nxt;
  logic [PAT_W-1:0]  w_mask;
  logic [FILL_W-1:0] w_fill_nxt;

  // Compare against the history as it will be after this bit lands, so the
  // match is reported in the same cycle the completing bit shifts.
  always_comb begin
    w_hist_nxt = {r_hist[PAT_W-2:0], bit_i};
    w_fill_nxt = (32'(r_fill) >= PAT_W) ? r_fill : r_fill + FILL_W'(1);
    w_mask     = ~({PAT_W{1'b1}} << cfg_len_i);
    match_o    = bit_valid_i
              && (32'(w_fill_nxt) >= 32'(cfg_len_i))
              && (((w_hist_nxt ^ cfg_pattern_i) & w_mask) == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr_i) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (bit_valid_i) begin
      r_hist <= w_hist_nxt;
      // Non-overlapping mode: the bits of a match cannot start the next one.
      r_fill <= (match_o && !cfg_overlap_i) ? '0 : w_fill_nxt;
    end
  end
endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: scans a word stream MSB-first for a configurable bit pattern.
//   clk, reset                 - clock, async active-low reset
//   start_i / stop_i           - start (latches cfg_*) / abort a scan
//   cfg_pattern_i, cfg_len_i   - pattern and its length (1..PAT_W)
//   cfg_overlap_i              - allow overlapping matches
//   cfg_words_i                - words per scan (1..255)
//   data_i/data_valid_i/data_ready_o - word handshake
//   det_o, det_pos_o           - match pulse and stream index of completing bit
//   match_cnt_o                - saturating match count of current/last scan
//   busy_o, done_o, err_o      - not idle / scan ended / illegal start
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int PAT_W  = PAT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [PAT_W-1:0]  cfg_pattern_i,
  input  logic [3:0]        cfg_len_i,
  input  logic              cfg_overlap_i,
  input  logic [7:0]        cfg_words_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  output logic              det_o,
  output logic [CNT_W-1:0]  det_pos_o,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int BL_W = $clog2(WORD_W + 1);
  localparam int WC_W = $clog2(MAX_WORDS + 1);

  state_e            r_state, w_state_nxt;
  logic [PAT_W-1:0]  r_pattern;
  logic [3:0]        r_len;
  logic              r_overlap;
  logic [WC_W-1:0]   r_words_cfg;
  logic [WORD_W-1:0] r_buf;
  logic [BL_W-1:0]   r_bits_left;
  logic [WC_W-1:0]   r_words;
  logic [CNT_W-1:0]  r_bit_idx;
  logic              r_det;
  logic [CNT_W-1:0]  r_det_pos;
  logic [CNT_W-1:0]  r_match_cnt;
  logic              r_err;

  logic w_legal, w_start_ok, w_shift, w_ready, w_accept, w_last_bit, w_match;

  assign w_legal    = (cfg_len_i != 4'd0) && (32'(cfg_len_i) <= PAT_W) && (cfg_words_i != 8'd0);
  assign w_start_ok = (r_state == IDLE) && start_i && w_legal;
  assign w_shift    = (r_state == RUN) && (r_bits_left != '0);
  // Refill while the last bit is shifting keeps the bit stream gap-free.
  // A word offered in the stop cycle would only be thrown away, so refuse it.
  assign w_ready    = (r_state == RUN) && !stop_i && (r_bits_left <= BL_W'(1))
                   && (r_words != r_words_cfg);
  assign w_accept   = w_ready && data_valid_i;
  assign w_last_bit = w_shift && (r_bits_left == BL_W'(1)) && (r_words == r_words_cfg);

  always_comb begin
    w_state_nxt  = r_state;
    data_ready_o = w_ready;
    busy_o       = (r_state != IDLE);
    done_o       = (r_state == FINISH);
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = RUN;
      RUN:     if (stop_i || w_last_bit) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .clk           (clk),
    .reset         (reset),
    .clr_i         (w_start_ok),
    .bit_valid_i   (w_shift),
    .bit_i         (r_buf[WORD_W-1]),
    .cfg_pattern_i (r_pattern),
    .cfg_len_i     (r_len),
    .cfg_overlap_i (r_overlap),
    .match_o       (w_match)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pattern   <= '0;
      r_len       <= '0;
      r_overlap   <= 1'b0;
      r_words_cfg <= '0;
      r_buf       <= '0;
      r_bits_left <= '0;
      r_words     <= '0;
      r_bit_idx   <= '0;
      r_det       <= 1'b0;
      r_det_pos   <= '0;
      r_match_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_det <= w_match;
      r_err <= (r_state == IDLE) && start_i && !w_legal;
      if (w_match) r_det_pos <= r_bit_idx;
      if (w_start_ok) begin
        r_pattern   <= cfg_pattern_i;
        r_len       <= cfg_len_i;
        r_overlap   <= cfg_overlap_i;
        r_words_cfg <= WC_W'(cfg_words_i);
        r_bits_left <= '0;
        r_words     <= '0;
        r_bit_idx   <= '0;
        r_match_cnt <= '0;
      end else if (r_state == RUN) begin
        if (w_accept) begin
          r_buf       <= data_i;
          r_bits_left <= BL_W'(WORD_W);
          r_words     <= r_words + WC_W'(1);
        end else if (stop_i) begin
          r_bits_left <= '0;
        end else if (w_shift) begin
          r_buf       <= r_buf << 1;
          r_bits_left <= r_bits_left - BL_W'(1);
        end
        if (w_shift) r_bit_idx <= r_bit_idx + CNT_W'(1);
        if (w_match && (r_match_cnt != '1)) r_match_cnt <= r_match_cnt + CNT_W'(1);
      end
    end
  end

  assign det_o       = r_det;
  assign det_pos_o   = r_det_pos;
  assign match_cnt_o = r_match_cnt;
  assign err_o       = r_err;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: directed and randomized scans checked against a
// behavioural pattern-search model of the bit stream.
module tb_seq_scan_ctrl;
  localparam int WORD_W = 16;
  localparam int PAT_W  = 12;
  localparam int CNT_W  = 16;

  logic clk = 1'b0, reset = 1'b0;
  logic start_i = 1'b0, stop_i = 1'b0, cfg_overlap_i = 1'b0, data_valid_i = 1'b0;
  logic [PAT_W-1:0]  cfg_pattern_i = '0;
  logic [3:0]        cfg_len_i = '0;
  logic [7:0]        cfg_words_i = '0;
  logic [WORD_W-1:0] data_i = '0;
  logic              data_ready_o, det_o, busy_o, done_o, err_o;
  logic [CNT_W-1:0]  det_pos_o, match_cnt_o;

  int errors = 0, checks = 0;
  int gcyc = 0, t0 = 0, done_cnt = 0, done_at = -1;
  int acc_at[256];
  int det_q[$], detc_q[$], exp_q[$];
  logic [WORD_W-1:0] words[256];

  seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .cfg_pattern_i(cfg_pattern_i), .cfg_len_i(cfg_len_i), .cfg_overlap_i(cfg_overlap_i),
    .cfg_words_i(cfg_words_i), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o), .det_o(det_o), .det_pos_o(det_pos_o),
    .match_cnt_o(match_cnt_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;
  always @(negedge clk) begin
    if (det_o) begin det_q.push_back(int'(det_pos_o)); detc_q.push_back(gcyc); end
    if (done_o) done_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic logic stream_bit(input int i);
    logic [WORD_W-1:0] w;
    w = words[i / WORD_W];
    return w[WORD_W-1 - (i % WORD_W)];
  endfunction

  // Windows of len bits ending at i equal to the pattern; without overlap a
  // window may not reuse any bit of the previously reported match.
  function automatic void build_model(input logic [PAT_W-1:0] pat, input int len,
                                      input logic ov, input int nbits);
    int  last_end;
    bit  hit;
    last_end = -1;
    exp_q.delete();
    for (int i = len - 1; i < nbits; i++) begin
      if (!ov && (i - len + 1 <= last_end)) continue;
      hit = 1;
      for (int j = 0; j < len; j++) if (stream_bit(i - j) !== pat[j]) hit = 0;
      if (hit) begin exp_q.push_back(i); last_end = i; end
    end
  endfunction

  function automatic bit det_matches();
    if (det_q.size() != exp_q.size()) return 0;
    foreach (det_q[i]) if (det_q[i] != exp_q[i]) return 0;
    return 1;
  endfunction

  function automatic int first_of(input bit use_det);
    if (use_det) return (det_q.size() > 0) ? det_q[0] : -1;
    return (exp_q.size() > 0) ? exp_q[0] : -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic start_scan(input logic [PAT_W-1:0] pat, input logic [3:0] len,
                            input logic ov, input logic [7:0] nw);
    @(negedge clk);
    cfg_pattern_i = pat; cfg_len_i = len; cfg_overlap_i = ov; cfg_words_i = nw;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    t0 = gcyc;
    det_q.delete(); detc_q.delete(); done_cnt = 0;
  endtask

  // Feeds words until done_o is seen; returns in the done_o cycle.
  task automatic run_feed(input int nw, input int stall_pct, input int stop_at,
                          input int budget, input bit noise);
    int wi;
    bit seen;
    wi = 0; seen = 0; done_at = -1;
    while (!seen && (gcyc - t0) < budget) begin
      if (done_o) begin
        seen = 1; done_at = gcyc - t0;
      end else begin
        data_valid_i = (wi < nw) && (int'($urandom_range(99)) >= stall_pct);
        data_i  = data_valid_i ? words[wi] : WORD_W'($urandom);
        stop_i  = ((gcyc - t0) == stop_at);
        start_i = noise && ($urandom_range(19) == 0);
        if (start_i) begin
          cfg_pattern_i = PAT_W'($urandom); cfg_len_i = 4'($urandom);
          cfg_words_i = 8'($urandom); cfg_overlap_i = 1'($urandom);
        end
        #1;
        if (data_valid_i && data_ready_o) begin acc_at[wi] = gcyc - t0; wi++; end
        @(negedge clk);
      end
    end
    data_valid_i = 1'b0; stop_i = 1'b0; start_i = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL scan_timeout: done_o not seen, got %0d cycles, required < %0d", gcyc - t0, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++;
    if ({data_ready_o, det_o, busy_o, done_o, err_o, det_pos_o, match_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b det=%b busy=%b done=%b err=%b pos=%0d cnt=%0d, required all 0",
               data_ready_o, det_o, busy_o, done_o, err_o, det_pos_o, match_cnt_o);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_match(input string nm);
    words[0] = 16'hEDB0;
    start_scan(12'hEDB, 4'd12, 1'b1, 8'd1);
    run_feed(1, 0, -1, 200, 0);
    build_model(12'hEDB, 12, 1'b1, 16);
    checks++;
    if (!det_matches() || exp_q.size() != 1 || exp_q[0] != 11) begin
      errors++;
      $display("FAIL %s_dets: got %0d pulses first %0d, required 1 pulse at 11", nm, det_q.size(), first_of(1));
    end
    checks++;
    if (detc_q.size() == 0 || detc_q[0] - t0 != 13) begin
      errors++;
      $display("FAIL %s_det_time: got cycle %0d, required 13", nm, detc_q.size() ? detc_q[0] - t0 : -1);
    end
    checks++;
    if (done_at != 17) begin
      errors++; $display("FAIL %s_done_time: got %0d, required 17", nm, done_at);
    end
    checks++;
    if (match_cnt_o !== 16'd1) begin
      errors++; $display("FAIL %s_count: got %0d, required 1", nm, match_cnt_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL %s_end: busy=%b done=%b pulses=%0d, required 0 0 1", nm, busy_o, done_o, done_cnt);
    end
  endtask

  task automatic test_overlap();
    for (int ov = 1; ov >= 0; ov--) begin
      words[0] = 16'hA800;
      start_scan(12'h005, 4'd3, 1'(ov), 8'd1);
      run_feed(1, 0, -1, 200, 0);
      build_model(12'h005, 3, 1'(ov), 16);
      checks++;
      if (!det_matches() || exp_q.size() != (ov ? 2 : 1)) begin
        errors++;
        $display("FAIL overlap%0d_dets: got %0d pulses first %0d, required %0d first %0d",
                 ov, det_q.size(), first_of(1), exp_q.size(), first_of(0));
      end
      checks++;
      if (match_cnt_o !== CNT_W'(ov ? 2 : 1)) begin
        errors++; $display("FAIL overlap%0d_count: got %0d, required %0d", ov, match_cnt_o, ov ? 2 : 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    words[0] = 16'h0003; words[1] = 16'hC000;
    start_scan(12'h00F, 4'd4, 1'b1, 8'd2);
    run_feed(2, 0, -1, 300, 0);
    build_model(12'h00F, 4, 1'b1, 32);
    checks++;
    if (acc_at[1] - acc_at[0] != 16) begin
      errors++; $display("FAIL b2b_accept_gap: got %0d, required 16", acc_at[1] - acc_at[0]);
    end
    checks++;
    if (!det_matches() || exp_q.size() != 1 || exp_q[0] != 17) begin
      errors++;
      $display("FAIL b2b_dets: got %0d pulses first %0d, required 1 at 17", det_q.size(), first_of(1));
    end
    checks++;
    if (match_cnt_o !== 16'd1 || done_at != 33) begin
      errors++; $display("FAIL b2b_end: cnt=%0d done_at=%0d, required 1 and 33", match_cnt_o, done_at);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [CNT_W-1:0] prev;
    logic [3:0] lens[3]  = '{4'd13, 4'd0, 4'd4};
    logic [7:0] nws[3]   = '{8'd1, 8'd1, 8'd0};
    for (int k = 0; k < 3; k++) begin
      prev = match_cnt_o;
      @(negedge clk);
      cfg_len_i = lens[k]; cfg_words_i = nws[k]; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin
        errors++; $display("FAIL illegal%0d_pulse: err=%b busy=%b, required 1 0", k, err_o, busy_o);
      end
      @(negedge clk);
      checks++;
      if (err_o !== 1'b0 || busy_o !== 1'b0 || match_cnt_o !== prev) begin
        errors++;
        $display("FAIL illegal%0d_after: err=%b busy=%b cnt=%0d, required 0 0 %0d", k, err_o, busy_o, match_cnt_o, prev);
      end
    end
  endtask

  task automatic test_stop();
    logic [PAT_W-1:0] pat;
    for (int i = 0; i < 4; i++) words[i] = WORD_W'($urandom);
    pat = PAT_W'(words[1] >> 13);
    start_scan(pat, 4'd3, 1'b1, 8'd4);
    run_feed(4, 0, 21, 300, 0);
    build_model(pat, 3, 1'b1, 21);
    checks++;
    if (done_at != 22 || data_ready_o !== 1'b0) begin
      errors++; $display("FAIL stop_finish: done_at=%0d rdy=%b, required 22 0", done_at, data_ready_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL stop_busy: got %b, required 0", busy_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!det_matches()) begin
      errors++;
      $display("FAIL stop_dets: got %0d pulses first %0d, required %0d first %0d",
               det_q.size(), first_of(1), exp_q.size(), first_of(0));
    end
    checks++;
    if (match_cnt_o !== CNT_W'(exp_q.size()) || done_cnt != 1) begin
      errors++;
      $display("FAIL stop_count: cnt=%0d pulses=%0d, required %0d 1", match_cnt_o, done_cnt, exp_q.size());
    end
  endtask

  task automatic test_start_stop();
    words[0] = 16'hF0F0;
    @(negedge clk);
    cfg_pattern_i = 12'h00F; cfg_len_i = 4'd4; cfg_overlap_i = 1'b0; cfg_words_i = 8'd1;
    start_i = 1'b1; stop_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0; t0 = gcyc;
    det_q.delete(); detc_q.delete(); done_cnt = 0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL start_stop_busy: got %b, required 1", busy_o);
    end
    run_feed(1, 0, -1, 200, 0);
    build_model(12'h00F, 4, 1'b0, 16);
    @(negedge clk);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    checks++;
    if (!det_matches() || busy_o !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL start_stop_scan: dets=%0d busy=%b pulses=%0d, required %0d 0 1",
               det_q.size(), busy_o, done_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    words[0] = 16'hEDB0;
    start_scan(12'hEDB, 4'd12, 1'b1, 8'd1);
    data_valid_i = 1'b1; data_i = words[0];
    @(negedge clk);
    data_valid_i = 1'b0;
    while (gcyc - t0 < 9) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({data_ready_o, det_o, busy_o, done_o, err_o, det_pos_o, match_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: rdy=%b det=%b busy=%b done=%b pos=%0d cnt=%0d, required all 0",
               data_ready_o, det_o, busy_o, done_o, det_pos_o, match_cnt_o);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt != 0 || busy_o !== 1'b0 || det_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: pulses=%0d busy=%b dets=%0d, required 0 0 0", done_cnt, busy_o, det_q.size());
    end
    test_single_match("rerun");
  endtask

  task automatic test_random();
    logic [PAT_W-1:0] pat;
    int len, nw, stall;
    logic ov;
    for (int s = 0; s < 25; s++) begin
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) words[i] = WORD_W'($urandom);
      len = $urandom_range(1, PAT_W);
      ov = 1'($urandom);
      stall = $urandom_range(0, 50);
      pat = ($urandom_range(1) == 0) ? PAT_W'(words[0] >> (WORD_W - len)) : PAT_W'($urandom);
      start_scan(pat, 4'(len), ov, 8'(nw));
      run_feed(nw, stall, -1, 2000, 1);
      build_model(pat, len, ov, nw * WORD_W);
      @(negedge clk);
      checks++;
      if (!det_matches()) begin
        errors++;
        $display("FAIL rand%0d_dets: got %0d pulses first %0d, required %0d first %0d",
                 s, det_q.size(), first_of(1), exp_q.size(), first_of(0));
      end
      checks++;
      if (match_cnt_o !== CNT_W'(exp_q.size()) || done_cnt != 1 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_end: cnt=%0d pulses=%0d busy=%b, required %0d 1 0",
                 s, match_cnt_o, done_cnt, busy_o, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_match("single");
    test_illegal();
    test_overlap();
    test_back_to_back();
    test_stop();
    test_start_stop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
